// File: rtl/regional_max_coord_stream_pkg.sv
// Shared types and default geometry for the regional-maxima coordinate stream.
//   state_t : scan FSM states (IDLE / SCAN / FLUSH)
//   coord_t : (row, column) pair at the default index widths
//   PIXELS  : number of pixels in the default M x N frame
package regional_max_pkg;

  localparam int CFG_M       = 4;
  localparam int CFG_N       = 4;
  localparam int CFG_I_WIDTH = 2;
  localparam int CFG_J_WIDTH = 2;
  localparam int PIXELS      = CFG_M * CFG_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [CFG_I_WIDTH-1:0] i;
    logic [CFG_J_WIDTH-1:0] j;
  } coord_t;

endpackage

// File: rtl/regional_max_coord_stream_raster_idx_cnt.sv
// Raster-order (row outer, column inner) pixel index counter.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : return to (0, 0); has priority over en_i
//   en_i       : advance one pixel, wrapping column then row
//   i_o, j_o   : current row / column
//   last_o     : current index is (M-1, N-1)
module raster_idx_cnt #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int I_WIDTH = 2,
  parameter int J_WIDTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [I_WIDTH-1:0] i_o,
  output logic [J_WIDTH-1:0] j_o,
  output logic               last_o
);

  logic [I_WIDTH-1:0] i_q, i_d;
  logic [J_WIDTH-1:0] j_q, j_d;
  logic               last_i, last_j;

  assign last_i = (i_q == I_WIDTH'(M - 1));
  assign last_j = (j_q == J_WIDTH'(N - 1));

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path
    // through this block leaves a signal unassigned (which would infer a latch).
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end else if (en_i) begin
      if (last_j) begin
        j_d = '0;
        i_d = last_i ? '0 : i_q + I_WIDTH'(1);
      end else begin
        j_d = j_q + J_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign last_o = last_i && last_j;

endmodule

// File: rtl/regional_max_coord_stream.sv
// Regional-maxima coordinate stream: captures the M x N maxima mask on start,
// scans it in raster order one pixel per cycle and emits (i, j) for every set
// bit on a valid/ready stream, then pulses done with the total beat count.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : scan request, accepted only in IDLE and not while done
//   mask                : maxima mask, captured on an accepted start
//   out_valid/out_ready : coordinate stream handshake
//   out_i, out_j        : coordinate of the current beat
//   busy                : scan or flush in progress
//   done                : one-cycle completion pulse
//   maxima_count        : beats emitted, held until the next accepted start
module regional_max_coord_stream
  import regional_max_pkg::*;
#(
  parameter int M         = CFG_M,
  parameter int N         = CFG_N,
  parameter int I_WIDTH   = CFG_I_WIDTH,
  parameter int J_WIDTH   = CFG_J_WIDTH,
  parameter int CNT_WIDTH = $clog2(M * N + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [M-1:0][N-1:0]   mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [I_WIDTH-1:0]    out_i,
  output logic [J_WIDTH-1:0]    out_j,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  maxima_count
);

  state_t                 state_q, state_d;
  logic [M-1:0][N-1:0]    mask_q, mask_d;
  logic                   out_valid_q, out_valid_d;
  logic [I_WIDTH-1:0]     out_i_q, out_i_d;
  logic [J_WIDTH-1:0]     out_j_q, out_j_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   done_q, done_d;

  logic [I_WIDTH-1:0]     idx_i;
  logic [J_WIDTH-1:0]     idx_j;
  logic                   idx_last;
  logic                   cnt_clr, cnt_en;
  logic                   slot_free;

  raster_idx_cnt #(
    .M       (M),
    .N       (N),
    .I_WIDTH (I_WIDTH),
    .J_WIDTH (J_WIDTH)
  ) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .i_o    (idx_i),
    .j_o    (idx_j),
    .last_o (idx_last)
  );

  // The output register may take a new beat when empty or being drained.
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    out_j_d     = out_j_q;
    count_d     = count_q;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The cycle that shows done is still IDLE; a start there is dropped.
        if (start && !done_q) begin
          mask_d  = mask;
          count_d = '0;
          cnt_clr = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (slot_free) begin
          if (mask_q[idx_i][idx_j]) begin
            out_valid_d = 1'b1;
            out_i_d     = idx_i;
            out_j_d     = idx_j;
            count_d     = count_q + CNT_WIDTH'(1);
          end else begin
            out_valid_d = 1'b0;
          end
          // Index parks on the last pixel; the next start clears it.
          if (idx_last) state_d = FLUSH;
          else          cnt_en  = 1'b1;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the captured mask is a plain register file, but it is reset so a
      // scan can never observe stale data from before reset.
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_j_q     <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_j_q     <= out_j_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_i        = out_i_q;
  assign out_j        = out_j_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign maxima_count = count_q;

endmodule

// File: tb/tb_regional_max_coord_stream.sv
// Directed bench for regional_max_coord_stream at M = N = 4.
// Edge E0 samples the accepted start; trace entry k is sampled on the falling
// edge after rising edge Ek as {busy, done, out_valid, out_i, out_j}, with the
// coordinate zeroed while out_valid is low.
module tb_regional_max_coord_stream;

  localparam int M    = 4;
  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int JW   = 2;
  localparam int CW   = 5;
  localparam int NCYC = 30;
  localparam int DONE_K = regional_max_pkg::PIXELS + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [M-1:0][N-1:0] mask;
  logic                out_valid;
  logic                out_ready;
  logic [IW-1:0]       out_i;
  logic [JW-1:0]       out_j;
  logic                busy;
  logic                done;
  logic [CW-1:0]       maxima_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0]    tr_obs [0:NCYC];
  logic [CW-1:0] tr_cnt [0:NCYC];

  regional_max_coord_stream #(
    .M (M), .N (N), .I_WIDTH (IW), .J_WIDTH (JW), .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mask         (mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_i        (out_i),
    .out_j        (out_j),
    .busy         (busy),
    .done         (done),
    .maxima_count (maxima_count)
  );

  always #5 clk = ~clk;

  // Drive start for one cycle so that it is sampled at E0; returns at E0+1.
  task automatic start_scan(input logic [15:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Records ncyc trace entries. out_ready is low during the cycles following
  // E(lo_first)..E(lo_last). A second start is sampled at E(restart_k) when
  // restart_k > 0; start_on_done raises start in the cycle done is shown.
  task automatic observe(input int ncyc, input int lo_first, input int lo_last,
                         input int restart_k, input logic [15:0] rmask,
                         input bit start_on_done);
    bit kill_start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      tr_obs[k] = {busy, done, out_valid, out_valid ? {out_i, out_j} : 4'b0};
      tr_cnt[k] = maxima_count;
      if (kill_start) begin
        start      = 1'b0;
        kill_start = 1'b0;
      end
      if (restart_k > 0 && k + 1 == restart_k) begin
        start = 1'b1; mask = rmask; kill_start = 1'b1;
      end
      if (start_on_done && done) begin
        start = 1'b1; mask = '1; kill_start = 1'b1;
      end
      out_ready = !(k >= lo_first && k <= lo_last);
    end
    out_ready = 1'b1;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mask = '0; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_i, out_j, busy, done, maxima_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%0d j=%0d busy=%b done=%b cnt=%0d, expected all zero",
               out_valid, out_i, out_j, busy, done, maxima_count);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_empty();
    logic [6:0] exp;
    start_scan(16'h0000);
    observe(18, 0, -1, 0, '0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      exp = (k < DONE_K) ? 7'b100_0000 : (k == DONE_K) ? 7'b010_0000 : 7'b0;
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL empty k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
    vectors++;
    if (tr_cnt[DONE_K] !== 5'd0) begin
      miscompares++;
      $display("FAIL empty_count: got %0d expected 0", tr_cnt[DONE_K]);
    end
  endtask

  task automatic test_single();
    logic [6:0] exp;
    start_scan(16'h0800);  // mask[2][3]
    observe(18, 0, -1, 0, '0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      if (k == 12)          exp = {3'b101, 2'd2, 2'd3};
      else if (k < DONE_K)  exp = 7'b100_0000;
      else if (k == DONE_K) exp = 7'b010_0000;
      else                  exp = 7'b0;
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL single k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
    vectors++;
    if (tr_cnt[DONE_K] !== 5'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d expected 1", tr_cnt[DONE_K]);
    end
  endtask

  // Also drives start in the done cycle; that start must be dropped.
  task automatic test_all_ones();
    logic [6:0] exp;
    start_scan(16'hFFFF);
    observe(20, 0, -1, 0, '0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      if (k < DONE_K)       exp = {3'b101, 2'((k - 1) / 4), 2'((k - 1) % 4)};
      else if (k == DONE_K) exp = 7'b010_0000;
      else                  exp = 7'b0;
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL all_ones k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
    for (int k = DONE_K; k <= 20; k++) begin
      vectors++;
      if (tr_cnt[k] !== 5'd16) begin
        miscompares++;
        $display("FAIL all_ones_count k=%0d: got %0d expected 16", k, tr_cnt[k]);
      end
    end
  endtask

  // Start accepted right after the previous scan; count restarts from zero.
  task automatic test_back_to_back();
    logic [6:0] exp;
    start_scan(16'h0001);
    observe(18, 0, -1, 0, '0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      if (k == 1)           exp = 7'b101_0000;
      else if (k < DONE_K)  exp = 7'b100_0000;
      else if (k == DONE_K) exp = 7'b010_0000;
      else                  exp = 7'b0;
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
    vectors++;
    if (tr_cnt[1] !== 5'd1) begin
      miscompares++;
      $display("FAIL back_to_back_count: got %0d expected 1", tr_cnt[1]);
    end
  endtask

  task automatic test_stall();
    logic [6:0] exp;
    start_scan(16'h0003);  // mask[0][0], mask[0][1]
    observe(23, 1, 5, 0, '0, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      if (k <= 6)                exp = 7'b101_0000;
      else if (k == 7)           exp = 7'b101_0001;
      else if (k < DONE_K + 5)   exp = 7'b100_0000;
      else if (k == DONE_K + 5)  exp = 7'b010_0000;
      else                       exp = 7'b0;
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL stall k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
    vectors++;
    if (tr_cnt[DONE_K + 5] !== 5'd2) begin
      miscompares++;
      $display("FAIL stall_count: got %0d expected 2", tr_cnt[DONE_K + 5]);
    end
  endtask

  // Second start at E5 with an all-ones mask must not disturb the scan.
  task automatic test_restart_ignored();
    logic [6:0] exp;
    start_scan(16'h0021);  // mask[0][0], mask[1][1]
    observe(18, 0, -1, 5, 16'hFFFF, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      if (k == 1)           exp = 7'b101_0000;
      else if (k == 6)      exp = 7'b101_0101;
      else if (k < DONE_K)  exp = 7'b100_0000;
      else if (k == DONE_K) exp = 7'b010_0000;
      else                  exp = 7'b0;
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL restart k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
    vectors++;
    if (tr_cnt[DONE_K] !== 5'd2) begin
      miscompares++;
      $display("FAIL restart_count: got %0d expected 2", tr_cnt[DONE_K]);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    start_scan(16'hFFFF);
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, out_i, out_j, busy} !== {1'b1, 2'd1, 2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset_beat: got v=%b i=%0d j=%0d busy=%b expected v=1 i=1 j=1 busy=1",
               out_valid, out_i, out_j, busy);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, busy, done, maxima_count} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b busy=%b done=%b cnt=%0d expected all zero",
               out_valid, busy, done, maxima_count);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 2) reset = 1'b0;
      vectors++;
      if ({done, busy, out_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL post_reset_idle c=%0d: got done=%b busy=%b v=%b expected 000",
                 c, done, busy, out_valid);
      end
    end
    start_scan(16'hFFFF);
    observe(3, 0, -1, 0, '0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      exp = {3'b101, 2'd0, 2'(k - 1)};
      vectors++;
      if (tr_obs[k] !== exp) begin
        miscompares++;
        $display("FAIL rescan k=%0d: got %b expected %b", k, tr_obs[k], exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_all_ones();
    test_back_to_back();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
